exception_sequencer: RTL

Multi-cycle sequencer that sits directly downstream of the combinational exception detector. When the detector raises an exception, this block latches the faulting address into EPC and records the cause. It then reads the one-byte handler address from the vector location in memory (0xFD overflow, 0xFE divide-by-zero, 0xFF invalid opcode) and issues a one-cycle PC load with that byte zero-extended. The main control unit stalls on `busy` while the sequence runs.

---
 rtl/exception_sequencer_if.sv | 27 ++
 rtl/exception_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/exception_sequencer_if.sv
// Bundle of detector, vector-memory and PC-load signals between the exception
// sequencer (master) and its surroundings (slave).
interface exception_sequencer_if;
    logic        exception;
    logic [2:0]  exception_code;
    logic [31:0] epc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        busy;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        timeout_err;

    modport master (
        input  exception, exception_code, epc_in, mem_ready, mem_rdata,
        output mem_req, mem_addr, epc, cause, busy, pc_load, pc_next, timeout_err
    );

    modport slave (
        output exception, exception_code, epc_in, mem_ready, mem_rdata,
        input  mem_req, mem_addr, epc, cause, busy, pc_load, pc_next, timeout_err
    );
endinterface

// File: rtl/exception_sequencer.sv
// Latches EPC/cause on an exception, fetches the one-byte handler vector from
// 0xFD-0xFF (with a timeout fallback) and issues a one-cycle PC load.
module exception_sequencer #(
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [31:0] DEFAULT_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    exception_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      epc_q, epc_d;
    logic [2:0]       cause_q, cause_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      pc_next_q, pc_next_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            epc_q      <= '0;
            cause_q    <= '0;
            mem_addr_q <= '0;
            pc_next_q  <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            mem_addr_q <= mem_addr_d;
            pc_next_q  <= pc_next_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        // NOTE: every target defaults to its held value first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        mem_addr_d = mem_addr_q;
        pc_next_d  = pc_next_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (bus.exception && (bus.exception_code != 3'b000)) begin
                    epc_d   = bus.epc_in;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    state_d = FETCH;
                    // Same bit0 > bit1 > bit2 priority as the detector.
                    if (bus.exception_code[0]) begin
                        cause_d    = 3'b001;
                        mem_addr_d = 32'h0000_00FD;
                    end else if (bus.exception_code[1]) begin
                        cause_d    = 3'b010;
                        mem_addr_d = 32'h0000_00FE;
                    end else begin
                        cause_d    = 3'b100;
                        mem_addr_d = 32'h0000_00FF;
                    end
                end
            end

            FETCH: begin
                if (bus.mem_ready) begin
                    pc_next_d = {24'b0, bus.mem_rdata};
                    state_d   = LOAD;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    pc_next_d = DEFAULT_PC;
                    tmo_d     = 1'b1;
                    state_d   = LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LOAD: begin
                tmo_d   = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = (state_q == FETCH);
        bus.busy        = (state_q != IDLE);
        bus.pc_load     = (state_q == LOAD);
        bus.timeout_err = (state_q == LOAD) && tmo_q;
    end

    assign bus.epc      = epc_q;
    assign bus.cause    = cause_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.pc_next  = pc_next_q;

endmodule
